// File: rtl/scr1_jtag_scan_pkg.sv
// rtl/scr1_jtag_scan_pkg.sv - command encodings, FSM states and tick constants for the JTAG scan master
package scr1_jtag_scan_pkg;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'b00,
    CMD_IR_SCAN   = 2'b01,
    CMD_DR_SCAN   = 2'b10,
    CMD_RESERVED  = 2'b11
  } cmd_type_e;

  // Each tick state is named after the TAP controller state the target
  // occupies while that tick runs; tms of the tick selects the next one.
  typedef enum logic [3:0] {
    IDLE,
    RESET_SEQ,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RTI,
    RESP
  } scan_state_e;

  // TAP reset: five tms=1 ticks reach Test-Logic-Reset, one tms=0 tick lands in Run-Test/Idle.
  localparam int unsigned RESET_TICKS    = 6;
  localparam int unsigned RESET_TMS_ONES = 5;

  localparam int unsigned STEP_W    = 3;
  localparam int unsigned BIT_CNT_W = 6;

endpackage

// File: rtl/scr1_jtag_tck_gen.sv
// rtl/scr1_jtag_tck_gen.sv - TCK phase divider with one-cycle rise/fall strobes
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   run         : high while ticks are to be generated; low parks tck at 0
//   tck         : registered JTAG clock
//   rise_tick   : high in the cycle whose closing clk edge drives tck 0->1
//   fall_tick   : high in the cycle whose closing clk edge drives tck 1->0 (tick end)
module scr1_jtag_tck_gen #(
  parameter int unsigned SCR1_TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CNT_W = $clog2(2 * SCR1_TCK_HALF);
  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(SCR1_TCK_HALF - 1);
  localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * SCR1_TCK_HALF - 1);

  logic [CNT_W-1:0] phase_cnt;

  assign rise_tick = run && (phase_cnt == RISE_AT);
  assign fall_tick = run && (phase_cnt == FALL_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      tck       <= 1'b0;
    end else if (!run) begin
      phase_cnt <= '0;
      tck       <= 1'b0;
    end else if (fall_tick) begin
      phase_cnt <= '0;
      tck       <= 1'b0;
    end else begin
      phase_cnt <= phase_cnt + CNT_W'(1);
      if (rise_tick) begin
        tck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scr1_jtag_scan_master.sv
// rtl/scr1_jtag_scan_master.sv - JTAG scan master: TAP reset, IR scan and DR scan commands
// Ports:
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_type, cmd_len_m1, cmd_data : command (type, scan length-1, TDI bits LSB first)
//   rsp_valid/rsp_ready/rsp_data   : response handshake and captured TDO bits
//   tck, tms, tdi, tdo          : JTAG pins (tdo already synchronised)
module scr1_jtag_scan_master
  import scr1_jtag_scan_pkg::*;
#(
  parameter int unsigned SCR1_MAX_LEN  = 32,
  parameter int unsigned SCR1_TCK_HALF = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [4:0]              cmd_len_m1,
  input  logic [SCR1_MAX_LEN-1:0] cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SCR1_MAX_LEN-1:0] rsp_data,
  output logic                    tck,
  output logic                    tms,
  output logic                    tdi,
  input  logic                    tdo
);

  localparam int unsigned IW = $clog2(SCR1_MAX_LEN);
  localparam logic [4:0] MAX_M1 = 5'(SCR1_MAX_LEN - 1);

  scan_state_e            state;
  logic                   run;
  logic                   is_ir;
  logic [4:0]             n_m1;
  logic [SCR1_MAX_LEN-1:0] data_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [STEP_W-1:0]      step_cnt;

  logic                   rise_tick;
  logic                   fall_tick;
  logic [4:0]             len_clamped;
  logic                   shift_last;

  scan_state_e            nxt_state;
  logic [BIT_CNT_W-1:0]   nxt_bit;
  logic [STEP_W-1:0]      nxt_step;
  logic                   last_tick;
  logic                   nxt_tms;
  logic                   nxt_tdi;

  scr1_jtag_tck_gen #(
    .SCR1_TCK_HALF (SCR1_TCK_HALF)
  ) u_tck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .tck       (tck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign cmd_ready   = (state == IDLE) && !rsp_valid;
  assign len_clamped = (cmd_len_m1 > MAX_M1) ? MAX_M1 : cmd_len_m1;
  assign shift_last  = (bit_cnt == {1'b0, n_m1});

  // Sequencing for the tick that starts at the next fall_tick, and the
  // tms/tdi it drives; evaluated from the state of the tick now ending.
  always_comb begin
    nxt_state = state;
    nxt_bit   = bit_cnt;
    nxt_step  = step_cnt;
    last_tick = 1'b0;
    case (state)
      RESET_SEQ: begin
        if (step_cnt == STEP_W'(RESET_TICKS - 1)) begin
          last_tick = 1'b1;
        end else begin
          nxt_step = step_cnt + STEP_W'(1);
        end
      end
      RTI:     nxt_state = SEL_DR;
      SEL_DR:  nxt_state = is_ir ? SEL_IR : CAPTURE;
      SEL_IR:  nxt_state = CAPTURE;
      CAPTURE: begin
        nxt_state = SHIFT;
        nxt_bit   = '0;
      end
      SHIFT: begin
        if (shift_last) begin
          nxt_state = EXIT1;
        end else begin
          nxt_bit = bit_cnt + BIT_CNT_W'(1);
        end
      end
      EXIT1:   nxt_state = UPDATE;
      UPDATE:  last_tick = 1'b1;
      default: ;
    endcase

    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    case (nxt_state)
      RESET_SEQ: nxt_tms = (nxt_step < STEP_W'(RESET_TMS_ONES));
      SEL_DR:    nxt_tms = is_ir;
      EXIT1:     nxt_tms = 1'b1;
      SHIFT: begin
        nxt_tms = (nxt_bit == {1'b0, n_m1});
        nxt_tdi = data_q[nxt_bit[IW-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      is_ir     <= 1'b0;
      n_m1      <= '0;
      data_q    <= '0;
      bit_cnt   <= '0;
      step_cnt  <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            data_q   <= cmd_data;
            n_m1     <= len_clamped;
            is_ir    <= (cmd_type == CMD_IR_SCAN);
            bit_cnt  <= '0;
            step_cnt <= '0;
            tdi      <= 1'b0;
            rsp_data <= '0;
            case (cmd_type_e'(cmd_type))
              CMD_TAP_RESET: begin
                state <= RESET_SEQ;
                tms   <= 1'b1;
                run   <= 1'b1;
              end
              CMD_IR_SCAN, CMD_DR_SCAN: begin
                // First tick leaves Run-Test/Idle towards Select-DR-Scan.
                state <= RTI;
                tms   <= 1'b1;
                run   <= 1'b1;
              end
              default: begin
                state     <= RESP;
                tms       <= 1'b0;
                rsp_valid <= 1'b1;
              end
            endcase
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          if (rise_tick && (state == SHIFT)) begin
            rsp_data[bit_cnt[IW-1:0]] <= tdo;
          end
          if (fall_tick) begin
            if (last_tick) begin
              state     <= RESP;
              run       <= 1'b0;
              tms       <= 1'b0;
              tdi       <= 1'b0;
              rsp_valid <= 1'b1;
            end else begin
              state    <= nxt_state;
              bit_cnt  <= nxt_bit;
              step_cnt <= nxt_step;
              tms      <= nxt_tms;
              tdi      <= nxt_tdi;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_jtag_scan_master.sv
// tb/tb_scr1_jtag_scan_master.sv - directed self-checking bench for scr1_jtag_scan_master
module tb_scr1_jtag_scan_master;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type   = 2'b00;
  logic [4:0]  cmd_len_m1 = 5'd0;
  logic [31:0] cmd_data   = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready  = 1'b0;
  logic [31:0] rsp_data;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo        = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_jtag_scan_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_len_m1 (cmd_len_m1),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo)
  );

  // Pin monitors: tick count, per-tick tms/tdi history (latest tick in bit 0), tck-high cycles.
  int unsigned tck_rises     = 0;
  int unsigned tck_hi_cycles = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;

  always @(posedge tck) begin
    tck_rises++;
    tms_log = {tms_log[62:0], tms};
    tdi_log = {tdi_log[62:0], tdi};
  end

  always @(posedge clk) if (tck) tck_hi_cycles++;

  // Target TAP model: 32-bit loopback DR, 5-bit IR capturing 00001.
  typedef enum logic [3:0] {
    TLR, RTI_S, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_e;

  tap_e        tap_st = TLR;
  logic [31:0] dr_reg = '0;
  logic [31:0] dr_sh  = '0;
  logic [4:0]  ir_reg = '0;
  logic [4:0]  ir_sh  = '0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR  : RTI_S;
      RTI_S:   return m ? SDR  : RTI_S;
      SDR:     return m ? SIR  : CDR;
      CDR:     return m ? E1DR : SHDR;
      SHDR:    return m ? E1DR : SHDR;
      E1DR:    return m ? UDR  : PDR;
      PDR:     return m ? E2DR : PDR;
      E2DR:    return m ? UDR  : SHDR;
      UDR:     return m ? SDR  : RTI_S;
      SIR:     return m ? TLR  : CIR;
      CIR:     return m ? E1IR : SHIR;
      SHIR:    return m ? E1IR : SHIR;
      E1IR:    return m ? UIR  : PIR;
      PIR:     return m ? E2IR : PIR;
      E2IR:    return m ? UIR  : SHIR;
      default: return m ? SDR  : RTI_S;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      CDR:     dr_sh  <= dr_reg;
      SHDR:    dr_sh  <= {tdi, dr_sh[31:1]};
      UDR:     dr_reg <= dr_sh;
      CIR:     ir_sh  <= 5'b00001;
      SHIR:    ir_sh  <= {tdi, ir_sh[4:1]};
      UIR:     ir_reg <= ir_sh;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    tdo <= (tap_st == SHDR) ? dr_sh[0] : (tap_st == SHIR) ? ir_sh[0] : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int unsigned rise0;
  int unsigned hi0;

  task automatic start_cmd(input logic [1:0] t, input logic [4:0] lm1, input logic [31:0] d);
    int n;
    @(negedge clk);
    cmd_type   = t;
    cmd_len_m1 = lm1;
    cmd_data   = d;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    rise0 = tck_rises;
    hi0   = tck_hi_cycles;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!rsp_valid && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic end_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [4:0] lm1, input logic [31:0] d,
                         output logic [31:0] rsp, output int cyc, output int ticks, output int hi);
    start_cmd(t, lm1, d);
    wait_rsp(cyc);
    rsp   = rsp_data;
    ticks = int'(tck_rises - rise0);
    hi    = int'(tck_hi_cycles - hi0);
    chk("tck_low_at_rsp", 64'(tck), 64'd0);
    end_rsp();
  endtask

  initial begin
    logic [31:0] rsp;
    logic [31:0] held;
    int cyc, ticks, hi, n, bad_rdy, bad_dat, seen_rsp;

    #200000;
    $display("FAIL global_timeout got=%0d exp=0", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rsp;
    logic [31:0] held;
    int cyc, ticks, hi, n, bad_rdy, bad_dat, seen_rsp;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;

    // TAP reset: 6 ticks of 4 cycles, tms 111110
    run_cmd(2'b00, 5'd0, 32'hFFFF_FFFF, rsp, cyc, ticks, hi);
    chk("tr_latency", 64'(cyc), 64'd24);
    chk("tr_ticks", 64'(ticks), 64'd6);
    chk("tr_tck_hi_cycles", 64'(hi), 64'd12);
    chk("tr_tms_seq", 64'(tms_log[5:0]), 64'(6'b111110));
    chk("tr_tdi_seq", 64'(tdi_log[5:0]), 64'd0);
    chk("tr_rsp", 64'(rsp), 64'd0);
    chk("idle_tms", 64'(tms), 64'd0);

    // IR scan N=5, 0x11
    run_cmd(2'b01, 5'd4, 32'h0000_0011, rsp, cyc, ticks, hi);
    chk("ir_latency", 64'(cyc), 64'd44);
    chk("ir_ticks", 64'(ticks), 64'd11);
    chk("ir_tms_seq", 64'(tms_log[10:0]), 64'(11'b11000000110));
    chk("ir_tdi_seq", 64'(tdi_log[10:0]), 64'(11'b00001000100));
    chk("ir_rsp", 64'(rsp), 64'h1);
    chk("ir_model_ir", 64'(ir_reg), 64'h11);

    // DR scan N=32, 0xDEADBEEF; the model DR starts at 0
    run_cmd(2'b10, 5'd31, 32'hDEAD_BEEF, rsp, cyc, ticks, hi);
    chk("dr32_latency", 64'(cyc), 64'd148);
    chk("dr32_ticks", 64'(ticks), 64'd37);
    chk("dr32_tms_seq", 64'(tms_log[36:0]), 64'({3'b100, 31'd0, 3'b110}));
    chk("dr32_tdi_seq", 64'(tdi_log[36:0]), 64'({3'b000, 32'hF77D_B57B, 2'b00}));
    chk("dr32_rsp_first", 64'(rsp), 64'h0);
    chk("dr32_model_dr", 64'(dr_reg), 64'hDEAD_BEEF);

    run_cmd(2'b10, 5'd31, 32'hDEAD_BEEF, rsp, cyc, ticks, hi);
    chk("dr32_rsp_loop", 64'(rsp), 64'hDEAD_BEEF);

    // DR scan N=1: single shift tick carries tms=1 and tdi=1
    run_cmd(2'b10, 5'd0, 32'h0000_0001, rsp, cyc, ticks, hi);
    chk("dr1_latency", 64'(cyc), 64'd24);
    chk("dr1_ticks", 64'(ticks), 64'd6);
    chk("dr1_tms_seq", 64'(tms_log[5:0]), 64'(6'b100110));
    chk("dr1_tdi_seq", 64'(tdi_log[5:0]), 64'(6'b000100));
    chk("dr1_rsp", 64'(rsp), 64'h1);

    // Reserved type: no tck activity, response the cycle after acceptance
    run_cmd(2'b11, 5'd31, 32'hFFFF_FFFF, rsp, cyc, ticks, hi);
    chk("rsv_latency", 64'(cyc), 64'd0);
    chk("rsv_ticks", 64'(ticks), 64'd0);
    chk("rsv_rsp", 64'(rsp), 64'd0);

    // Back-pressure: DR N=4 captures low nibble of 0xEF56DF77 left by the N=1 scan
    start_cmd(2'b10, 5'd3, 32'h0000_000A);
    wait_rsp(cyc);
    chk("bp_latency", 64'(cyc), 64'd36);
    held = rsp_data;
    chk("bp_rsp", 64'(held), 64'h7);
    cmd_type   = 2'b11;
    cmd_len_m1 = 5'd0;
    cmd_data   = 32'hFFFF_FFFF;
    cmd_valid  = 1'b1;
    bad_rdy = 0;
    bad_dat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) bad_rdy++;
      if (rsp_data !== held || !rsp_valid) bad_dat++;
    end
    chk("bp_cmd_ready_low", 64'(bad_rdy), 64'd0);
    chk("bp_rsp_stable", 64'(bad_dat), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("bp_rsp_valid_dropped", 64'(rsp_valid), 64'd0);
    rise0 = tck_rises;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_second_rsp_data", 64'(rsp_data), 64'd0);
    chk("bp_second_no_tck", 64'(tck_rises - rise0), 64'd0);
    end_rsp();

    // Reset during tick 3 of a DR scan
    start_cmd(2'b10, 5'd7, 32'h0000_005A);
    n = 0;
    while (int'(tck_rises - rise0) < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_tick3", 64'(tck_rises - rise0), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tck", 64'(tck), 64'd0);
    chk("mid_rst_tms", 64'(tms), 64'd1);
    chk("mid_rst_tdi", 64'(tdi), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rise0 = tck_rises;
    seen_rsp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    chk("mid_no_rsp", 64'(seen_rsp), 64'd0);
    chk("mid_no_tck", 64'(tck_rises - rise0), 64'd0);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);

    // Recovery: TAP reset then an IR scan
    run_cmd(2'b00, 5'd0, 32'd0, rsp, cyc, ticks, hi);
    chk("rec_tr_latency", 64'(cyc), 64'd24);
    chk("rec_tr_rsp", 64'(rsp), 64'd0);
    run_cmd(2'b01, 5'd4, 32'h0000_0003, rsp, cyc, ticks, hi);
    chk("rec_ir_rsp", 64'(rsp), 64'h1);
    chk("rec_ir_model_ir", 64'(ir_reg), 64'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
